// File: rtl/sync_fifo_pkg.sv
`default_nettype none
//==============================================================================
// Module : sync_fifo_pkg
// Desc   : Shared types and elaboration helpers for the single-clock FIFO.
// Rev    : 1.0 - initial release
//==============================================================================
package sync_fifo_pkg;

    localparam int DEFAULT_ASIZE = 4;

    typedef struct packed {
        logic wfull;
        logic rempty;
        logic almost_full;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } fifo_status_t;

    function automatic int fifo_depth(input int asize);
        return 1 << asize;
    endfunction

    // Out-of-range thresholds are pulled into the legal window instead of
    // producing a flag that can never (or always) assert.
    function automatic int th_clamp(input int th, input int lo, input int hi);
        if (th < lo) return lo;
        if (th > hi) return hi;
        return th;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo_ctrl.sv
`default_nettype none
//==============================================================================
// Module : sync_fifo_ctrl
// Desc   : Pointers, occupancy count, flag decode and sticky error flags.
// Rev    : 1.0 - initial release
//==============================================================================
module sync_fifo_ctrl
    import sync_fifo_pkg::*;
#(
    parameter int ASIZE     = DEFAULT_ASIZE,
    parameter int AFULL_TH  = (1 << ASIZE) - 2,
    parameter int AEMPTY_TH = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_winc,
    input  logic               i_rinc,
    input  logic               i_flush,
    input  logic               i_clr_err,
    output logic [ASIZE-1:0]   o_waddr,
    output logic [ASIZE-1:0]   o_raddr,
    output logic               o_we,
    output logic               o_re,
    output logic [ASIZE:0]     o_count,
    output fifo_status_t       o_status
);

    localparam int C_DEPTH      = fifo_depth(ASIZE);
    localparam int C_AFULL_INT  = th_clamp(AFULL_TH, 1, C_DEPTH);
    localparam int C_AEMPTY_INT = th_clamp(AEMPTY_TH, 0, C_DEPTH - 1);
    localparam logic [ASIZE:0] C_AFULL  = C_AFULL_INT[ASIZE:0];
    localparam logic [ASIZE:0] C_AEMPTY = C_AEMPTY_INT[ASIZE:0];
    localparam logic [ASIZE:0] C_ONE    = {{ASIZE{1'b0}}, 1'b1};

    logic [ASIZE:0] r_wptr;
    logic [ASIZE:0] r_rptr;
    logic [ASIZE:0] r_count;
    logic           r_overflow;
    logic           r_underflow;

    logic w_full;
    logic w_empty;
    logic w_we;
    logic w_re;
    logic w_ovf_set;
    logic w_udf_set;

    // Full when the pointers sit on the same slot but one has lapped the other.
    assign w_full  = (r_wptr[ASIZE] != r_rptr[ASIZE]) &&
                     (r_wptr[ASIZE-1:0] == r_rptr[ASIZE-1:0]);
    assign w_empty = (r_wptr == r_rptr);

    assign w_we      = i_winc && !w_full  && !i_flush;
    assign w_re      = i_rinc && !w_empty && !i_flush;
    assign w_ovf_set = i_winc && w_full  && !i_flush;
    assign w_udf_set = i_rinc && w_empty && !i_flush;

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_we) r_wptr <= r_wptr + C_ONE;
            if (w_re) r_rptr <= r_rptr + C_ONE;
            case ({w_we, w_re})
                2'b10:   r_count <= r_count + C_ONE;
                2'b01:   r_count <= r_count - C_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // A new error event outranks a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= w_ovf_set || (r_overflow  && !i_clr_err);
            r_underflow <= w_udf_set || (r_underflow && !i_clr_err);
        end
    end

    assign o_waddr = r_wptr[ASIZE-1:0];
    assign o_raddr = r_rptr[ASIZE-1:0];
    assign o_we    = w_we;
    assign o_re    = w_re;
    assign o_count = r_count;

    assign o_status.wfull        = w_full;
    assign o_status.rempty       = w_empty;
    assign o_status.almost_full  = (r_count >= C_AFULL);
    assign o_status.almost_empty = (r_count <= C_AEMPTY);
    assign o_status.overflow     = r_overflow;
    assign o_status.underflow    = r_underflow;

endmodule
`default_nettype wire

// File: rtl/sync_fifo_flags.sv
`default_nettype none
//==============================================================================
// Module : sync_fifo_flags
// Desc   : Single-clock FIFO with count, thresholds, flush and FWFT option.
// Rev    : 1.0 - initial release
//==============================================================================
module sync_fifo_flags
    import sync_fifo_pkg::*;
#(
    parameter int ASIZE     = 4,
    parameter int DSIZE     = 8,
    parameter int AFULL_TH  = (1 << ASIZE) - 2,
    parameter int AEMPTY_TH = 1,
    parameter int FWFT      = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             winc,
    input  logic [DSIZE-1:0] wdata,
    input  logic             rinc,
    output logic [DSIZE-1:0] rdata,
    output logic             wfull,
    output logic             rempty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [ASIZE:0]   count,
    input  logic             flush,
    input  logic             clr_err,
    output logic             overflow,
    output logic             underflow
);

    localparam int C_DEPTH = fifo_depth(ASIZE);

    logic [DSIZE-1:0] r_mem [C_DEPTH];
    logic [ASIZE-1:0] w_waddr;
    logic [ASIZE-1:0] w_raddr;
    logic             w_we;
    logic             w_re;
    fifo_status_t     w_status;

    sync_fifo_ctrl #(
        .ASIZE     (ASIZE),
        .AFULL_TH  (AFULL_TH),
        .AEMPTY_TH (AEMPTY_TH)
    ) u_ctrl (
        .clk       (clk),
        .rst       (rst),
        .i_winc    (winc),
        .i_rinc    (rinc),
        .i_flush   (flush),
        .i_clr_err (clr_err),
        .o_waddr   (w_waddr),
        .o_raddr   (w_raddr),
        .o_we      (w_we),
        .o_re      (w_re),
        .o_count   (count),
        .o_status  (w_status)
    );

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_we) r_mem[w_waddr] <= wdata;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            logic w_re_unused;
            assign w_re_unused = w_re;
            assign rdata = w_status.rempty ? '0 : r_mem[w_raddr];
        end else begin : g_std
            logic [DSIZE-1:0] r_rdata;
            always_ff @(posedge clk) begin
                if (rst)       r_rdata <= '0;
                else if (w_re) r_rdata <= r_mem[w_raddr];
            end
            assign rdata = r_rdata;
        end
    endgenerate

    assign wfull        = w_status.wfull;
    assign rempty       = w_status.rempty;
    assign almost_full  = w_status.almost_full;
    assign almost_empty = w_status.almost_empty;
    assign overflow     = w_status.overflow;
    assign underflow    = w_status.underflow;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_flags.sv
`default_nettype none
//==============================================================================
// Module : tb_sync_fifo_flags
// Desc   : Directed self-checking bench, standard and FWFT instances.
// Rev    : 1.0 - initial release
//==============================================================================
module tb_sync_fifo_flags;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    int         checks = 0;
    int         errors = 0;

    // Instance 0: standard read mode
    logic       w0 = 0, r0 = 0, f0 = 0, c0 = 0;
    logic [7:0] wd0 = 8'h00;
    logic [7:0] rd0;
    logic       full0, empty0, af0, ae0, ovf0, udf0;
    logic [2:0] cnt0;

    // Instance 1: first-word-fall-through
    logic       w1 = 0, r1 = 0, f1 = 0, c1 = 0;
    logic [7:0] wd1 = 8'h00;
    logic [7:0] rd1;
    logic       full1, empty1, af1, ae1, ovf1, udf1;
    logic [2:0] cnt1;

    always #5 clk = ~clk;

    sync_fifo_flags #(.ASIZE(2), .DSIZE(8), .AFULL_TH(3), .AEMPTY_TH(1), .FWFT(0)) dut0 (
        .clk(clk), .rst(rst), .winc(w0), .wdata(wd0), .rinc(r0), .rdata(rd0),
        .wfull(full0), .rempty(empty0), .almost_full(af0), .almost_empty(ae0),
        .count(cnt0), .flush(f0), .clr_err(c0), .overflow(ovf0), .underflow(udf0)
    );

    sync_fifo_flags #(.ASIZE(2), .DSIZE(8), .AFULL_TH(3), .AEMPTY_TH(1), .FWFT(1)) dut1 (
        .clk(clk), .rst(rst), .winc(w1), .wdata(wd1), .rinc(r1), .rdata(rd1),
        .wfull(full1), .rempty(empty1), .almost_full(af1), .almost_empty(ae1),
        .count(cnt1), .flush(f1), .clr_err(c1), .overflow(ovf1), .underflow(udf1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        step(); step();
        rst = 0;

        // Reset state
        chk("rst_count", cnt0, 0);   chk("rst_rempty", empty0, 1);
        chk("rst_wfull", full0, 0);  chk("rst_afull", af0, 0);
        chk("rst_aempty", ae0, 1);   chk("rst_ovf", ovf0, 0);
        chk("rst_udf", udf0, 0);     chk("rst_rdata", rd0, 8'h00);

        // Fill with four words
        w0 = 1; wd0 = 8'h11; step();
        chk("w1_count", cnt0, 1); chk("w1_rempty", empty0, 0); chk("w1_aempty", ae0, 1);
        wd0 = 8'h22; step();
        chk("w2_count", cnt0, 2); chk("w2_aempty", ae0, 0); chk("w2_afull", af0, 0);
        wd0 = 8'h33; step();
        chk("w3_count", cnt0, 3); chk("w3_afull", af0, 1); chk("w3_wfull", full0, 0);
        wd0 = 8'h44; step();
        chk("w4_count", cnt0, 4); chk("w4_wfull", full0, 1);
        wd0 = 8'h55; step();
        chk("w5_ovf", ovf0, 1); chk("w5_count", cnt0, 4);

        // Clear, then simultaneous read/write on full
        w0 = 0; c0 = 1; step();
        chk("clr_ovf", ovf0, 0);
        c0 = 0; w0 = 1; wd0 = 8'h55; r0 = 1; step();
        chk("fr_rdata", rd0, 8'h11); chk("fr_count", cnt0, 3);
        chk("fr_ovf", ovf0, 1);      chk("fr_wfull", full0, 0);

        // Flush with concurrent write
        r0 = 0; f0 = 1; wd0 = 8'h66; step();
        chk("fl_count", cnt0, 0);  chk("fl_rempty", empty0, 1);
        chk("fl_aempty", ae0, 1);  chk("fl_ovf", ovf0, 1);
        chk("fl_rdata", rd0, 8'h11);
        f0 = 0; w0 = 0; step();
        chk("fl_wr_ignored", cnt0, 0);

        // Underflow and clear precedence
        r0 = 1; step();
        chk("uf_set", udf0, 1); chk("uf_count", cnt0, 0); chk("uf_rdata", rd0, 8'h11);
        r0 = 0; c0 = 1; step();
        chk("uf_clr", udf0, 0); chk("ovf_clr2", ovf0, 0);
        r0 = 1; c0 = 1; step();
        chk("uf_set_wins", udf0, 1);
        r0 = 0; c0 = 1; step();
        c0 = 0;

        // Streaming pairs across pointer wrap
        w0 = 1; wd0 = 8'h00; step();
        chk("wr_first_count", cnt0, 1);
        r0 = 1;
        for (int i = 1; i < 10; i++) begin
            wd0 = 8'(i); step();
            chk("wrap_rdata", rd0, 32'(i - 1));
            chk("wrap_count", cnt0, 1);
        end
        w0 = 0; step();
        chk("wrap_last", rd0, 8'h09); chk("wrap_empty", empty0, 1);
        chk("wrap_ovf", ovf0, 0);     chk("wrap_udf", udf0, 0);

        // Mid-stream reset
        r0 = 0; w0 = 1; wd0 = 8'hAA; step();
        w0 = 0; r0 = 1; step();
        chk("ms_rdata", rd0, 8'hAA);
        step();
        chk("ms_udf", udf0, 1);
        r0 = 0; w0 = 1; wd0 = 8'hBB; step();
        rst = 1; step();
        chk("mr_count", cnt0, 0); chk("mr_rempty", empty0, 1); chk("mr_wfull", full0, 0);
        chk("mr_afull", af0, 0);  chk("mr_aempty", ae0, 1);   chk("mr_udf", udf0, 0);
        chk("mr_rdata", rd0, 8'h00);
        rst = 0; w0 = 0;

        // FWFT instance
        chk("fw_rempty0", empty1, 1);
        w1 = 1; wd1 = 8'hA5; step();
        chk("fw_rempty", empty1, 0); chk("fw_rdata", rd1, 8'hA5); chk("fw_count", cnt1, 1);
        w1 = 0; step();
        chk("fw_hold", rd1, 8'hA5);
        r1 = 1; step();
        chk("fw_pop_empty", empty1, 1); chk("fw_pop_count", cnt1, 0);
        r1 = 0; w1 = 1; wd1 = 8'hB6; step();
        wd1 = 8'hC7; step();
        w1 = 0;
        chk("fw_head", rd1, 8'hB6);
        r1 = 1; step();
        chk("fw_next", rd1, 8'hC7); chk("fw_cnt1", cnt1, 1);
        r1 = 0; step();
        chk("fw_udf", udf1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
